if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, fetch address after reset; SHALL be word-aligned.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 hazard_detected_signal  in  1  downstream stall; the presented instruction is not consumed this cycle.
REQ-005 br_taken  in  1  redirect request; single-cycle pulse.
REQ-006 br_target  in  `ADDRESS_LEN  redirect address; bits [1:0] SHALL be ignored and treated as 00.
REQ-007 imem_req  out  1  instruction-memory request.
REQ-008 imem_addr  out  `ADDRESS_LEN  word-aligned fetch address.
REQ-009 imem_ack  in  1  memory response; imem_rdata is valid in the same cycle; zero-wait ack is legal.
REQ-010 imem_rdata  in  `ADDRESS_LEN  fetched instruction word.
REQ-011 pc_out  out  `ADDRESS_LEN  fetch address + 4 of the presented instruction.
REQ-012 instruction_out  out  `ADDRESS_LEN  presented instruction; 0 (NOP) on a bubble.
REQ-013 valid_out  out  1  instruction_out holds a real instruction.

Function
REQ-014 States SHALL be FETCH, HOLD and DROP; all outputs SHALL be registered.
REQ-015 FETCH: imem_req=1 and imem_addr=pc; address SHALL stay stable until imem_ack.
REQ-016 FETCH, ack, no stall, no branch: next edge loads instruction_out=rdata, pc_out=pc+4, valid_out=1, pc=pc+4; remain in FETCH.
REQ-017 FETCH, ack, stall: rdata and pc+4 go to a one-entry buffer, pc=pc+4, go to HOLD; outputs hold.
REQ-018 FETCH, no ack, no stall: next edge loads a bubble (instruction_out=0, pc_out=0, valid_out=0).
REQ-019 Any state with stall and no branch: pc_out, instruction_out and valid_out SHALL hold.
REQ-020 HOLD: imem_req=0; on the first cycle without stall, the buffer loads onto the outputs at the edge and the state returns to FETCH.
REQ-021 br_taken SHALL take priority over stall and ack: pc=br_target, buffer is cleared, outputs become a bubble at the next edge.
REQ-022 br_taken in FETCH with no ack: go to DROP; imem_req stays 1 at the old address until ack; the response is discarded; then FETCH at br_target.
REQ-023 br_taken in FETCH with ack: rdata is discarded; next cycle is FETCH at br_target.
REQ-024 br_taken in DROP: pc is updated; the state remains DROP.
REQ-025 DROP: outputs are bubbles; stall is ignored.
REQ-026 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 At most one request SHALL be outstanding; imem_req SHALL never drop before ack while in FETCH or DROP.

Reset
REQ-028 While rst=1 at an edge: state=FETCH, pc=PC_RESET, buffer empty, imem_req=0, and pc_out, instruction_out and valid_out=0.
REQ-029 On the first cycle after rst deasserts: imem_req=1, imem_addr=PC_RESET.
REQ-030 Reset mid-request SHALL abandon the request without waiting for ack; a late ack SHALL be ignored.

Configuration
REQ-031 With macro IF_STALL_CNT_EN defined: output port stall_cnt [15:0] counts cycles with hazard_detected_signal=1, saturates at 16'hFFFF, and resets to 0.
REQ-032 Without IF_STALL_CNT_EN: the stall_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset release, zero-wait memory returning addr^32'hA5A5_0000 -> consecutive valid outputs with pc_out 4, 8, 12 and no bubbles.
REQ-034 Memory with ack 3 cycles after req -> 3 bubbles between valid instructions; imem_addr is stable during each wait.
REQ-035 Stall asserted for 4 cycles on an ack cycle -> outputs hold, HOLD with imem_req=0; the buffered word presents the cycle after release; no word is lost or duplicated.
REQ-036 br_taken to 32'h0000_0103 while a request is pending, ack 2 cycles later -> stale data is not presented; the next fetch address is 32'h0000_0100.
REQ-037 PC_RESET=32'hFFFF_FFFC, zero-wait memory -> pc_out=0 on the first instruction; the second fetch address is 0.
REQ-038 IF_STALL_CNT_EN, stall held 70000 cycles -> stall_cnt=16'hFFFF; rst -> 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding memory request, one-entry buffer for downstream stalls.
// Define IF_STALL_CNT_EN to add the stall_cnt output (saturating count of stalled cycles).
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif

module if_stage #(
    parameter logic [`ADDRESS_LEN-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hazard_detected_signal,
    input  logic                    br_taken,
    input  logic [`ADDRESS_LEN-1:0] br_target,
    output logic                    imem_req,
    output logic [`ADDRESS_LEN-1:0] imem_addr,
    input  logic                    imem_ack,
    input  logic [`ADDRESS_LEN-1:0] imem_rdata,
    output logic [`ADDRESS_LEN-1:0] pc_out,
    output logic [`ADDRESS_LEN-1:0] instruction_out,
`ifdef IF_STALL_CNT_EN
    output logic                    valid_out,
    output logic [15:0]             stall_cnt
`else
    output logic                    valid_out
`endif
);

    localparam int unsigned AW = `ADDRESS_LEN;
    localparam logic [AW-1:0] WordMask = ~AW'(3);
    localparam logic [AW-1:0] PcInit   = PC_RESET & WordMask;

    typedef enum logic [1:0] {StFetch, StHold, StDrop} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            req_q, req_d;
    logic [AW-1:0]   buf_instr_q, buf_instr_d;
    logic [AW-1:0]   buf_pc_q, buf_pc_d;
    logic [AW-1:0]   pc_out_q, pc_out_d;
    logic [AW-1:0]   instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            ack;
    logic [AW-1:0]   pc_inc;
    logic [AW-1:0]   br_addr;

    // An ack only counts against a request we actually issued; late acks after reset are dropped.
    assign ack     = imem_ack & req_q;
    assign pc_inc  = pc_q + AW'(4);
    assign br_addr = br_target & WordMask;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        pc_out_d    = pc_out_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        if (br_taken) begin
            pc_d        = br_addr;
            buf_instr_d = '0;
            buf_pc_d    = '0;
            pc_out_d    = '0;
            instr_d     = '0;
            valid_d     = 1'b0;
            // An unanswered request must drain before the target can be fetched.
            state_d     = (req_q && !ack) ? StDrop : StFetch;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (ack) begin
                        pc_d = pc_inc;
                        if (hazard_detected_signal) begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = pc_inc;
                            state_d     = StHold;
                        end else begin
                            instr_d  = imem_rdata;
                            pc_out_d = pc_inc;
                            valid_d  = 1'b1;
                        end
                    end else if (!hazard_detected_signal) begin
                        pc_out_d = '0;
                        instr_d  = '0;
                        valid_d  = 1'b0;
                    end
                end
                StHold: begin
                    if (!hazard_detected_signal) begin
                        instr_d  = buf_instr_q;
                        pc_out_d = buf_pc_q;
                        valid_d  = 1'b1;
                        state_d  = StFetch;
                    end
                end
                StDrop: begin
                    pc_out_d = '0;
                    instr_d  = '0;
                    valid_d  = 1'b0;
                    if (ack) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
        req_d  = (state_d != StHold);
        // While draining, the old address stays on the bus even if pc was redirected.
        addr_d = (state_d == StDrop) ? addr_q : pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= PcInit;
            addr_q      <= PcInit;
            req_q       <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            pc_out_q    <= '0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            pc_out_q    <= pc_out_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
        end
    end

    assign imem_req        = req_q;
    assign imem_addr       = addr_q;
    assign pc_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;

`ifdef IF_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_detected_signal && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run against a
// program-order reference model. Stall-counter checks compile only with IF_STALL_CNT_EN.
module tb_if_stage;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        hz;
    logic        br;
    logic [31:0] bt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr;
    logic        valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_pc_out;
    logic [31:0] w_instr;
    logic        w_valid;
    logic        w_ack;
    logic [31:0] w_rdata;
`ifdef IF_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] w_stall_cnt;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          mem_lat;
    int          wait_cnt;
    bit          outstanding;
    logic [31:0] req_log[$];

    always #5 clk = ~clk;

    if_stage dut (
        .clk                    (clk),
        .rst                    (rst),
        .hazard_detected_signal (hz),
        .br_taken               (br),
        .br_target              (bt),
        .imem_req               (imem_req),
        .imem_addr              (imem_addr),
        .imem_ack               (imem_ack),
        .imem_rdata             (imem_rdata),
        .pc_out                 (pc_out),
        .instruction_out        (instr),
`ifdef IF_STALL_CNT_EN
        .valid_out              (valid),
        .stall_cnt              (stall_cnt)
`else
        .valid_out              (valid)
`endif
    );

    // Second instance for the address wrap case, on an always-ready memory.
    assign w_ack   = w_req;
    assign w_rdata = w_addr ^ K;

    if_stage #(.PC_RESET(32'hFFFF_FFFC)) dut_w (
        .clk                    (clk),
        .rst                    (rst),
        .hazard_detected_signal (1'b0),
        .br_taken               (1'b0),
        .br_target              (32'h0),
        .imem_req               (w_req),
        .imem_addr              (w_addr),
        .imem_ack               (w_ack),
        .imem_rdata             (w_rdata),
        .pc_out                 (w_pc_out),
        .instruction_out        (w_instr),
`ifdef IF_STALL_CNT_EN
        .valid_out              (w_valid),
        .stall_cnt              (w_stall_cnt)
`else
        .valid_out              (w_valid)
`endif
    );

    // Memory model: fixed latency (mem_lat >= 0) or random 0..3 per request (mem_lat < 0).
    task automatic drive_mem();
        if (imem_req === 1'b1) begin
            if (!outstanding) begin
                outstanding = 1'b1;
                wait_cnt = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
                req_log.push_back(imem_addr);
            end
            if (wait_cnt == 0) begin
                imem_ack    = 1'b1;
                imem_rdata  = imem_addr ^ K;
                outstanding = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_cnt--;
            end
        end else begin
            imem_ack    = 1'b0;
            imem_rdata  = $urandom;
            outstanding = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        drive_mem();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hz  = 1'b0;
        br  = 1'b0;
        bt  = '0;
        step();
        step();
        rst = 1'b0;
        outstanding = 1'b0;
        req_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; hz = 1'b0; br = 1'b0; bt = '0; mem_lat = 0;
        step();
        step();
        n_vec++;
        if ({imem_req, valid, pc_out, instr} !== 66'h0) begin
            n_err++;
            $display("FAIL reset_outputs: req=%b valid=%b pc_out=%h instr=%h want all 0",
                     imem_req, valid, pc_out, instr);
        end
        n_vec++;
        if (w_req !== 1'b0) begin
            n_err++; $display("FAIL reset_w_req: got %b want 0", w_req);
        end
        rst = 1'b0;
        step();
        n_vec++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_err++; $display("FAIL reset_first_req: req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
        n_vec++;
        if ({w_req, w_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_err++; $display("FAIL reset_w_first_req: req=%b addr=%h want 1/fffffffc", w_req, w_addr);
        end
    endtask

    task automatic test_zero_wait();
        do_reset();
        mem_lat = 0;
        step();
        for (int k = 1; k <= 3; k++) begin
            step();
            n_vec++;
            if ({valid, pc_out, instr} !== {1'b1, 32'(4 * k), 32'(4 * k - 4) ^ K}) begin
                n_err++;
                $display("FAIL zero_wait_%0d: valid=%b pc_out=%h instr=%h want 1/%h/%h",
                         k, valid, pc_out, instr, 32'(4 * k), 32'(4 * k - 4) ^ K);
            end
        end
    endtask

    task automatic test_latency();
        logic        pre_req, pre_ack;
        logic [31:0] pre_addr;
        do_reset();
        mem_lat = 3;
        for (int i = 0; i < 24; i++) begin
            drive_mem();
            pre_req = imem_req; pre_ack = imem_ack; pre_addr = imem_addr;
            tick();
            if (pre_req && !pre_ack) begin
                n_vec++;
                if ({imem_req, imem_addr} !== {1'b1, pre_addr}) begin
                    n_err++;
                    $display("FAIL latency_addr_stable: req=%b addr=%h want 1/%h",
                             imem_req, imem_addr, pre_addr);
                end
            end
            // Request rises at tick 0 and each word takes 4 cycles: 3 bubbles between words.
            n_vec++;
            if (valid !== (i > 0 && i % 4 == 0)) begin
                n_err++; $display("FAIL latency_valid_%0d: got %b", i, valid);
            end
            if (i > 0 && i % 4 == 0) begin
                n_vec++;
                if (pc_out !== 32'(i)) begin
                    n_err++; $display("FAIL latency_pc_%0d: got %h want %h", i, pc_out, 32'(i));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] p, ins;
        do_reset();
        mem_lat = 0;
        step(); step(); step();
        p = pc_out; ins = instr;
        hz = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if ({valid, pc_out, instr, imem_req} !== {1'b1, p, ins, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold_%0d: valid=%b pc_out=%h instr=%h req=%b want 1/%h/%h/0",
                         i, valid, pc_out, instr, imem_req, p, ins);
            end
        end
        hz = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            n_vec++;
            if ({valid, pc_out, instr} !== {1'b1, p + 32'(4 * i), (p + 32'(4 * i - 4)) ^ K}) begin
                n_err++;
                $display("FAIL stall_release_%0d: valid=%b pc_out=%h instr=%h want 1/%h/%h",
                         i, valid, pc_out, instr, p + 32'(4 * i), (p + 32'(4 * i - 4)) ^ K);
            end
        end
    endtask

    task automatic test_branch();
        bit found = 1'b0;
        do_reset();
        mem_lat = 3;
        step();
        step();
        br = 1'b1; bt = 32'h0000_0103;
        step();
        br = 1'b0;
        n_vec++;
        if ({imem_req, imem_addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL branch_drop: req=%b addr=%h valid=%b want 1/0/0", imem_req, imem_addr, valid);
        end
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = valid;
        end
        n_vec++;
        if ({found, pc_out, instr} !== {1'b1, 32'h104, 32'h100 ^ K}) begin
            n_err++;
            $display("FAIL branch_first: found=%b pc_out=%h instr=%h want 1/104/%h",
                     found, pc_out, instr, 32'h100 ^ K);
        end
        n_vec++;
        if (req_log.size() < 2 || req_log[1] !== 32'h100) begin
            n_err++;
            $display("FAIL branch_next_addr: size=%0d want second fetch at 00000100", req_log.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        step();
        n_vec++;
        if ({w_valid, w_pc_out, w_instr, w_addr} !== {1'b1, 32'h0, 32'hFFFF_FFFC ^ K, 32'h0}) begin
            n_err++;
            $display("FAIL wrap: valid=%b pc_out=%h instr=%h addr=%h want 1/0/%h/0",
                     w_valid, w_pc_out, w_instr, w_addr, 32'hFFFF_FFFC ^ K);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        do_reset();
        mem_lat = 3;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (imem_req !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_req: got %b want 0", imem_req);
        end
        // Late ack for the abandoned request.
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; outstanding = 1'b0;
        tick();
        n_vec++;
        if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL reset_mid_late_ack: valid=%b req=%b addr=%h want 0/1/0",
                     valid, imem_req, imem_addr);
        end
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = valid;
        end
        n_vec++;
        if ({found, pc_out, instr} !== {1'b1, 32'h4, K}) begin
            n_err++;
            $display("FAIL reset_mid_first: found=%b pc_out=%h instr=%h want 1/4/%h",
                     found, pc_out, instr, K);
        end
    endtask

    // Reference: instructions are consumed in program order; a redirect restarts the order at the
    // aligned target; bubbles are all-zero; stalls freeze the outputs; the bus holds until ack.
    task automatic test_random();
        logic [31:0] exp_next = 32'h0;
        int          consumed = 0;
        logic        pre_req, pre_ack;
        logic [31:0] pre_addr, p_pc, p_ins;
        logic        p_v;
        do_reset();
        mem_lat = -1;
        for (int c = 0; c < 3000; c++) begin
            hz = ($urandom_range(0, 99) < 30);
            br = ($urandom_range(0, 99) < 4);
            bt = $urandom;
            if (valid && !hz && !br) begin
                n_vec++;
                if ({pc_out, instr} !== {exp_next + 32'd4, exp_next ^ K}) begin
                    n_err++;
                    $display("FAIL rand_order c=%0d: pc_out=%h instr=%h want %h/%h",
                             c, pc_out, instr, exp_next + 32'd4, exp_next ^ K);
                end
                exp_next += 32'd4;
                consumed++;
            end
            if (br) exp_next = bt & ~32'd3;
            if (!valid) begin
                n_vec++;
                if ({pc_out, instr} !== 64'h0) begin
                    n_err++;
                    $display("FAIL rand_bubble c=%0d: pc_out=%h instr=%h want 0/0", c, pc_out, instr);
                end
            end
            drive_mem();
            pre_req = imem_req; pre_ack = imem_ack; pre_addr = imem_addr;
            p_pc = pc_out; p_ins = instr; p_v = valid;
            tick();
            if (pre_req && !pre_ack) begin
                n_vec++;
                if ({imem_req, imem_addr} !== {1'b1, pre_addr}) begin
                    n_err++;
                    $display("FAIL rand_addr_stable c=%0d: req=%b addr=%h want 1/%h",
                             c, imem_req, imem_addr, pre_addr);
                end
            end
            if (br) begin
                n_vec++;
                if ({valid, pc_out, instr} !== 65'h0) begin
                    n_err++; $display("FAIL rand_branch_bubble c=%0d: valid=%b pc_out=%h", c, valid, pc_out);
                end
            end else if (hz) begin
                n_vec++;
                if ({valid, pc_out, instr} !== {p_v, p_pc, p_ins}) begin
                    n_err++;
                    $display("FAIL rand_hold c=%0d: valid=%b pc_out=%h instr=%h want %b/%h/%h",
                             c, valid, pc_out, instr, p_v, p_pc, p_ins);
                end
            end
        end
        hz = 1'b0; br = 1'b0;
        n_vec++;
        if (consumed < 200) begin
            n_err++; $display("FAIL rand_progress: consumed %0d want >= 200", consumed);
        end
    endtask

`ifdef IF_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        mem_lat = 0;
        n_vec++;
        if (stall_cnt !== 16'h0) begin
            n_err++; $display("FAIL stall_cnt_reset: got %h want 0", stall_cnt);
        end
        hz = 1'b1;
        for (int i = 0; i < 70000; i++) step();
        n_vec++;
        if (stall_cnt !== 16'hFFFF) begin
            n_err++; $display("FAIL stall_cnt_sat: got %h want ffff", stall_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; hz = 1'b0;
        n_vec++;
        if (stall_cnt !== 16'h0) begin
            n_err++; $display("FAIL stall_cnt_clear: got %h want 0", stall_cnt);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        imem_ack = 1'b0; imem_rdata = '0; outstanding = 1'b0; wait_cnt = 0;
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef IF_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
